// File: rtl/fpu_mul_pkg.sv
// Shared constants and types for the FP32 multiplier arbiter slice.
// Tag entries are sized for the largest supported requester count.
package fpu_mul_pkg;

  localparam int DW        = 32;
  localparam int MAX_REQ   = 8;
  localparam int CNT_W     = 16;
  localparam int TAG_MAX_W = $clog2(MAX_REQ);

  typedef logic [CNT_W-1:0] cnt_t;

  typedef struct packed {
    logic                 vld;
    logic [TAG_MAX_W-1:0] tag;
  } tag_ent_t;

  function automatic int tag_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fpu_mul_arbiter_rr_arbiter.sv
// Round-robin arbiter, combinational grant searching from ptr+1; ptr moves to the winner on advance.
// Zero latency; a requester holding req is granted within N cycles.
module rr_arbiter
  import fpu_mul_pkg::*;
#(
  parameter  int N  = 4,
  localparam int IW = tag_w(N)
) (
  input  logic          aclk,
  input  logic          areset,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx
);

  logic [IW-1:0] ptr;

  always_comb begin
    logic          found;
    logic [IW-1:0] idx;
    found     = 1'b0;
    idx       = '0;
    grant     = '0;
    grant_idx = '0;
    for (int off = 1; off <= N; off++) begin
      idx = IW'((int'(ptr) + off) % N);
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

  // Reset to the last slot so the first search starts at requester 0.
  always_ff @(posedge aclk) begin
    if (areset)
      ptr <= IW'(N - 1);
    else if (advance)
      ptr <= grant_idx;
  end

endmodule

// File: rtl/fpu_mul_arbiter.sv
// Shares one pipelined FP32 multiplier among N_REQ valid/ready requesters; accept at t -> rsp at t+1+MUL_LAT.
// Requests stall while enable=0; responses have no backpressure and must be taken on the pulse.
module fpu_mul_arbiter
  import fpu_mul_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int MUL_LAT = 3,
  parameter int DW      = fpu_mul_pkg::DW
) (
  input  logic                aclk,
  input  logic                areset,
  input  logic                enable,
  input  logic [N_REQ-1:0]    req_valid,
  output logic [N_REQ-1:0]    req_ready,
  input  logic [N_REQ*DW-1:0] req_a,
  input  logic [N_REQ*DW-1:0] req_b,
  output logic [N_REQ-1:0]    rsp_valid,
  output logic [DW-1:0]       rsp_data,
  output logic                mul_valid,
  output logic [DW-1:0]       mul_a,
  output logic [DW-1:0]       mul_b,
  input  logic [DW-1:0]       mul_result,
  output logic                busy,
  output logic [CNT_W-1:0]    issue_cnt
);

  localparam int IW = tag_w(N_REQ);

  logic [N_REQ-1:0] arb_req;
  logic [N_REQ-1:0] grant;
  logic [IW-1:0]    grant_idx;
  logic             accept;
  logic [DW-1:0]    sel_a;
  logic [DW-1:0]    sel_b;
  logic [IW-1:0]    iss_tag;
  tag_ent_t         tag_pipe [MUL_LAT];
  tag_ent_t         tag_exit;
  logic             pipe_any;

  assign arb_req   = req_valid & {N_REQ{enable}};
  assign req_ready = grant;
  assign accept    = |grant;

  rr_arbiter #(.N(N_REQ)) u_arb (
    .aclk      (aclk),
    .areset    (areset),
    .req       (arb_req),
    .advance   (accept),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        sel_a = req_a[i*DW +: DW];
        sel_b = req_b[i*DW +: DW];
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      mul_valid <= 1'b0;
      mul_a     <= '0;
      mul_b     <= '0;
      iss_tag   <= '0;
      issue_cnt <= '0;
    end else begin
      mul_valid <= accept;
      if (accept) begin
        mul_a     <= sel_a;
        mul_b     <= sel_b;
        iss_tag   <= grant_idx;
        issue_cnt <= issue_cnt + cnt_t'(1);
      end
    end
  end

  // Tag shadow pipe: the last stage lines up with mul_result for the same op.
  always_ff @(posedge aclk) begin
    if (areset) begin
      for (int k = 0; k < MUL_LAT; k++)
        tag_pipe[k] <= '0;
    end else begin
      tag_pipe[0].vld <= mul_valid;
      tag_pipe[0].tag <= TAG_MAX_W'(iss_tag);
      for (int k = 1; k < MUL_LAT; k++)
        tag_pipe[k] <= tag_pipe[k-1];
    end
  end

  assign tag_exit = tag_pipe[MUL_LAT-1];

  always_comb begin
    rsp_valid = '0;
    pipe_any  = 1'b0;
    for (int i = 0; i < N_REQ; i++)
      if (tag_exit.vld && (tag_exit.tag == TAG_MAX_W'(i)))
        rsp_valid[i] = 1'b1;
    for (int k = 0; k < MUL_LAT; k++)
      pipe_any = pipe_any | tag_pipe[k].vld;
  end

  assign rsp_data = tag_exit.vld ? mul_result : '0;
  assign busy     = mul_valid | pipe_any;

endmodule

// File: tb/tb_fpu_mul_arbiter.sv
// Bench for fpu_mul_arbiter: table-driven grant vectors, hand sequences, response scoreboard.
// A behavioural fixed-latency FP32 multiplier sits on the mul_* side.
module tb_fpu_mul_arbiter;

  localparam int N = 4;
  localparam int L = 3;
  localparam int W = 32;

  logic           aclk = 1'b0;
  logic           areset = 1'b1;
  logic           enable = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a = '0;
  logic [N*W-1:0] req_b = '0;
  logic [N-1:0]   rsp_valid;
  logic [W-1:0]   rsp_data;
  logic           mul_valid;
  logic [W-1:0]   mul_a;
  logic [W-1:0]   mul_b;
  logic [W-1:0]   mul_result;
  logic           busy;
  logic [15:0]    issue_cnt;

  fpu_mul_arbiter #(.N_REQ(N), .MUL_LAT(L), .DW(W)) dut (
    .aclk       (aclk),
    .areset     (areset),
    .enable     (enable),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .mul_valid  (mul_valid),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_result (mul_result),
    .busy       (busy),
    .issue_cnt  (issue_cnt)
  );

  always #5 aclk = ~aclk;

  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  // Truncating FP32 multiply, adequate for the normal operands used here.
  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic       s;
    logic [9:0] e;
    logic [47:0] m;
    s = a[31] ^ b[31];
    if (a[30:0] == 31'd0 || b[30:0] == 31'd0) return {s, 31'd0};
    m = {1'b1, a[22:0]} * {1'b1, b[22:0]};
    e = {2'b0, a[30:23]} + {2'b0, b[30:23]} - 10'd127;
    if (m[47]) return {s, e[7:0] + 8'd1, m[46:24]};
    return {s, e[7:0], m[45:23]};
  endfunction

  function automatic logic [31:0] fpow2(input int e);
    return {1'b0, 8'(127 + e), 23'd0};
  endfunction

  logic [W-1:0] mstage [L];
  always @(posedge aclk) begin
    mstage[0] <= mul_valid ? fmul(mul_a, mul_b) : '0;
    for (int k = 1; k < L; k++) mstage[k] <= mstage[k-1];
  end
  assign mul_result = mstage[L-1];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [N-1:0] oh;
    logic [31:0]  data;
    int           cyc;
  } exp_t;

  exp_t sbq[$];
  bit   sb_off = 1'b0;
  int   rsp_cnt [N];

  always @(negedge aclk) begin
    exp_t e;
    if (!areset && !sb_off) begin
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          e.oh    = '0;
          e.oh[i] = 1'b1;
          e.data  = fmul(req_a[i*W +: W], req_b[i*W +: W]);
          e.cyc   = cyc;
          sbq.push_back(e);
        end
      end
      if (rsp_valid != '0) begin
        if (sbq.size() == 0) begin
          chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
        end else begin
          e = sbq.pop_front();
          chk("rsp_owner", 32'(rsp_valid), 32'(e.oh));
          chk("rsp_data", rsp_data, e.data);
          chk("rsp_latency", 32'(cyc - e.cyc), 32'(1 + L));
          for (int i = 0; i < N; i++) if (rsp_valid[i]) rsp_cnt[i]++;
        end
      end
    end
  end

  typedef struct {
    logic         en;
    logic [N-1:0] rv;
    logic [N-1:0] exp_rdy;
  } vec_t;

  vec_t tbl [16];

  task automatic do_reset();
    @(posedge aclk); #1;
    areset    = 1'b1;
    req_valid = '0;
    repeat (4) @(posedge aclk);
    #1;
    areset = 1'b0;
    sbq.delete();
    for (int i = 0; i < N; i++) rsp_cnt[i] = 0;
  endtask

  task automatic drain();
    req_valid = '0;
    repeat (L + 4) @(posedge aclk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] kf [5];
    logic [N-1:0] e5 [3];
    bit   got;
    int   t0;

    // Rows 0-7: all requesters held; rows 8-15: sparse patterns and enable gating.
    for (int r = 0; r < 8; r++) tbl[r] = '{1'b1, 4'b1111, 4'b0001 << (r % 4)};
    tbl[8]  = '{1'b1, 4'b1010, 4'b0010};
    tbl[9]  = '{1'b1, 4'b1010, 4'b1000};
    tbl[10] = '{1'b0, 4'b0100, 4'b0000};
    tbl[11] = '{1'b1, 4'b0100, 4'b0100};
    tbl[12] = '{1'b1, 4'b0101, 4'b0001};
    tbl[13] = '{1'b1, 4'b0000, 4'b0000};
    tbl[14] = '{1'b1, 4'b1100, 4'b0100};
    tbl[15] = '{1'b1, 4'b1100, 4'b1000};
    kf = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000};
    e5 = '{4'b0100, 4'b0001, 4'b0010};

    // Reset state
    do_reset();
    @(negedge aclk);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_mul_valid", 32'(mul_valid), 32'd0);
    chk("rst_mul_a", mul_a, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_issue_cnt", 32'(issue_cnt), 32'd0);

    // Single op from requester 0: 1.5 * 2.0
    @(posedge aclk); #1;
    enable         = 1'b1;
    req_valid      = 4'b0001;
    req_a[0 +: W]  = 32'h3FC00000;
    req_b[0 +: W]  = 32'h40000000;
    @(negedge aclk);
    chk("t1_ready", 32'(req_ready), 32'h1);
    t0 = cyc;
    @(posedge aclk); #1;
    req_valid = '0;
    @(negedge aclk);
    chk("t1_mul_valid", 32'(mul_valid), 32'd1);
    chk("t1_mul_a", mul_a, 32'h3FC00000);
    chk("t1_mul_b", mul_b, 32'h40000000);
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_issue_cnt", 32'(issue_cnt), 32'd1);
    got = 1'b0;
    for (int k = 0; k < 12 && !got; k++) begin
      @(negedge aclk);
      if (rsp_valid != '0) begin
        got = 1'b1;
        chk("t1_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("t1_rsp_lat", 32'(cyc - t0), 32'd4);
        chk("t1_rsp_data", rsp_data, 32'h40400000);
      end
    end
    chk("t1_rsp_seen", 32'(got), 32'd1);
    @(posedge aclk); #1;
    drain();

    // Grant table
    do_reset();
    for (int i = 0; i < N; i++) req_a[i*W +: W] = fpow2(i);
    for (int r = 0; r < 16; r++) begin
      @(posedge aclk); #1;
      enable    = tbl[r].en;
      req_valid = tbl[r].rv;
      for (int i = 0; i < N; i++) req_b[i*W +: W] = fpow2(r % 3);
      @(negedge aclk);
      chk($sformatf("tbl_rdy_%0d", r), 32'(req_ready), 32'(tbl[r].exp_rdy));
    end
    @(posedge aclk); #1;
    enable = 1'b1;
    drain();
    chk("tbl_rsp_cnt0", 32'(rsp_cnt[0]), 32'd3);
    chk("tbl_rsp_cnt1", 32'(rsp_cnt[1]), 32'd3);
    chk("tbl_rsp_cnt2", 32'(rsp_cnt[2]), 32'd4);
    chk("tbl_rsp_cnt3", 32'(rsp_cnt[3]), 32'd4);

    // Back-to-back from requester 2
    do_reset();
    enable = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge aclk); #1;
      req_valid         = 4'b0100;
      req_a[2*W +: W]   = kf[k];
      req_b[2*W +: W]   = 32'h3F800000;
      @(negedge aclk);
      chk("t3_ready", 32'(req_ready), 32'h4);
      if (k > 0) chk("t3_mul_valid_run", 32'(mul_valid), 32'd1);
    end
    @(posedge aclk); #1;
    req_valid = '0;
    @(negedge aclk);
    chk("t3_mul_valid_last", 32'(mul_valid), 32'd1);
    @(negedge aclk);
    chk("t3_mul_valid_end", 32'(mul_valid), 32'd0);
    chk("t3_issue_cnt", 32'(issue_cnt), 32'd5);
    @(posedge aclk); #1;
    drain();

    // enable low holds off grants while in-flight work drains
    req_valid = 4'b1000;
    @(negedge aclk);
    chk("t4_first", 32'(req_ready), 32'h8);
    @(posedge aclk); #1;
    enable    = 1'b0;
    req_valid = 4'b0010;
    for (int k = 0; k < 8; k++) begin
      @(negedge aclk);
      chk("t4_held", 32'(req_ready), 32'd0);
      @(posedge aclk); #1;
    end
    chk("t4_busy_drained", 32'(busy), 32'd0);
    enable = 1'b1;
    @(negedge aclk);
    chk("t4_regrant", 32'(req_ready), 32'h2);
    @(posedge aclk); #1;
    drain();

    // Reset with three ops in flight
    for (int k = 0; k < 3; k++) begin
      req_valid = 4'b0111;
      @(negedge aclk);
      chk("t5_ready", 32'(req_ready), 32'(e5[k]));
      @(posedge aclk); #1;
    end
    req_valid = '0;
    areset    = 1'b1;
    sbq.delete();
    @(posedge aclk); #1;
    areset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge aclk);
      chk("t5_no_rsp", 32'(rsp_valid), 32'd0);
    end
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_issue_cnt", 32'(issue_cnt), 32'd0);
    @(posedge aclk); #1;
    req_valid = 4'b1111;
    @(negedge aclk);
    chk("t5_first_grant", 32'(req_ready), 32'h1);
    @(posedge aclk); #1;
    drain();

    // Issue counter wrap
    do_reset();
    sb_off    = 1'b1;
    enable    = 1'b1;
    req_valid = 4'b0001;
    repeat (65535) @(posedge aclk);
    #1;
    drain();
    chk("t6_cnt_max", 32'(issue_cnt), 32'h0000FFFF);
    sb_off    = 1'b0;
    req_valid = 4'b0001;
    @(negedge aclk);
    chk("t6_ready", 32'(req_ready), 32'h1);
    @(posedge aclk); #1;
    req_valid = '0;
    @(negedge aclk);
    chk("t6_cnt_wrap", 32'(issue_cnt), 32'd0);
    @(posedge aclk); #1;
    drain();
    chk("sb_empty", 32'(sbq.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
